capture_sequencer: RTL and testbench

Sequences acquisition into the five channel sample RAMs of `LA_dig`. It applies the decimation ratio, steps the circular write address and arms the trigger logic once enough pre-trigger history is stored. After a trigger it counts the post-trigger samples, then flags capture-done and reports where the oldest sample sits so the dump engine can replay the buffer in order. It sits between the sample-clock domain front end (`smpl_vld`), the trigger logic (`armed`/`triggered`) and the command-config registers (`decimator`, `trig_pos`, `run`, `capture_done`).

---
 rtl/capture_sequencer.sv | 116 +++++++++++
 tb/tb_capture_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Acquisition sequencer for the LA_dig channel sample RAMs: decimation, circular write addressing, arming and post-trigger count.
// Optional CAP_TRIG_ADDR_EN macro registers the address of the last pre-trigger write on trig_addr.
module capture_sequencer #(
    parameter int ENTRIES = 384,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              smpl_vld,
    input  logic [3:0]        decimator,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              run,
    input  logic              capture_done,
    input  logic              triggered,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              set_capture_done,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] trig_addr
);

    typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W + 1)'(ENTRIES);

    state_t            state, state_nxt;
    logic [15:0]       dec_cnt, dec_max;
    logic              kept, start, trig_take, enter_done;
    logic [ADDR_W-1:0] tp, post_cnt, waddr_inc;
    logic [ADDR_W:0]   pre_cnt, pre_cnt_nxt, pre_thresh;

    always_comb begin
        tp          = (trig_pos > LAST) ? LAST : trig_pos;
        pre_thresh  = DEPTH - {1'b0, tp};
        dec_max     = (16'd1 << decimator) - 16'd1;
        kept        = smpl_vld && (dec_cnt == dec_max);
        we          = ((state == PRE) || (state == POST)) && kept;
        waddr_inc   = (waddr == LAST) ? '0 : waddr + 1'b1;
        pre_cnt_nxt = pre_cnt;
        if ((state == PRE) && we && (pre_cnt < pre_thresh))
            pre_cnt_nxt = pre_cnt + 1'b1;
        trig_take = (state == PRE) && run && triggered && armed;

        state_nxt = state;
        case (state)
            IDLE: if (run && !capture_done) state_nxt = PRE;
            PRE: begin
                if (!run)
                    state_nxt = IDLE;
                else if (trig_take)
                    state_nxt = (tp == '0) ? DONE : POST;
            end
            POST: begin
                if (!run)
                    state_nxt = IDLE;
                else if (we && ((post_cnt + 1'b1) == tp))
                    state_nxt = DONE;
            end
            // capture_done is still low during the pulse cycle, so it cannot count as a host clear yet
            DONE: if (!run || (!capture_done && !set_capture_done)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        start      = (state == IDLE) && (state_nxt == PRE);
        enter_done = (state != DONE) && (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            dec_cnt          <= '0;
            waddr            <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
            start_addr       <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                dec_cnt <= '0;
            else if (((state == PRE) || (state == POST)) && smpl_vld)
                dec_cnt <= kept ? 16'd0 : dec_cnt + 16'd1;
            if (start)
                waddr <= '0;
            else if (we)
                waddr <= waddr_inc;
            pre_cnt <= start ? '0 : pre_cnt_nxt;
            if (start)
                post_cnt <= '0;
            else if ((state == POST) && we)
                post_cnt <= post_cnt + 1'b1;
            armed            <= (state == PRE) && (state_nxt == PRE) && (pre_cnt_nxt >= pre_thresh);
            set_capture_done <= enter_done;
            // Oldest sample of a full buffer is the next location that would have been written
            if (enter_done)
                start_addr <= we ? waddr_inc : waddr;
        end
    end

`ifdef CAP_TRIG_ADDR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trig_addr <= '0;
        else if (start)
            trig_addr <= '0;
        else if (trig_take)
            trig_addr <= we ? waddr : ((waddr == '0) ? LAST : waddr - 1'b1);
    end
`else
    assign trig_addr = '0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer; trig_addr expectations follow CAP_TRIG_ADDR_EN.
module tb_capture_sequencer;

    localparam int ENTRIES = 384;
    localparam int ADDR_W  = 9;

    logic              clk = 1'b0;
    logic              rst_n, smpl_vld, run, capture_done, triggered;
    logic [3:0]        decimator;
    logic [ADDR_W-1:0] trig_pos;
    logic              we, armed, set_capture_done;
    logic [ADDR_W-1:0] waddr, start_addr, trig_addr;

    int checks = 0;
    int failures = 0;
    int wr_total = 0;
    int pulse_total = 0;
    int wr_base, pulse_base, n;
    int exp_trig;

    capture_sequencer #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .decimator(decimator),
        .trig_pos(trig_pos), .run(run), .capture_done(capture_done), .triggered(triggered),
        .we(we), .waddr(waddr), .armed(armed), .set_capture_done(set_capture_done),
        .start_addr(start_addr), .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) wr_total++;
        if (set_capture_done === 1'b1) pulse_total++;
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task applyStimulus(input logic s, input logic r, input logic cd, input logic t);
        smpl_vld     = s;
        run          = r;
        capture_done = cd;
        triggered    = t;
        #1;
    endtask

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task waitArmed(input int max_cycles);
        n = 0;
        while (armed !== 1'b1 && n < max_cycles) begin
            tick();
            #1;
            n++;
        end
        checkOutput("armed_timeout", 32'(armed), 1);
    endtask

    task waitDone(input int max_cycles);
        n = 0;
        while (set_capture_done !== 1'b1 && n < max_cycles) begin
            tick();
            #1;
            n++;
        end
        checkOutput("done_timeout", 32'(set_capture_done), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        decimator = 4'd0;
        trig_pos = 9'd100;
        smpl_vld = 1'b0; run = 1'b0; capture_done = 1'b0; triggered = 1'b0;
        #2;
        checkOutput("rst_we", 32'(we), 0);
        checkOutput("rst_waddr", 32'(waddr), 0);
        checkOutput("rst_armed", 32'(armed), 0);
        checkOutput("rst_done", 32'(set_capture_done), 0);
        checkOutput("rst_start_addr", 32'(start_addr), 0);
        checkOutput("rst_trig_addr", 32'(trig_addr), 0);
        #13 rst_n = 1'b1;

        // Capture 1: decim 0, trig_pos 100, trigger on address 333
        tick();
        applyStimulus(1, 1, 0, 0);
        wr_base = wr_total;
        pulse_base = pulse_total;
        checkOutput("idle_we", 32'(we), 0);
        waitArmed(1000);
        checkOutput("pre_writes_at_arm", 32'(wr_total - wr_base), 284);
        checkOutput("waddr_at_arm", 32'(waddr), 284);
        n = 0;
        while (waddr != 9'd333 && n < 200) begin
            tick();
            #1;
            n++;
        end
        applyStimulus(1, 1, 0, 1);
        checkOutput("trig_cycle_waddr", 32'(waddr), 333);
        checkOutput("trig_cycle_we", 32'(we), 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        checkOutput("pre_writes_total", 32'(wr_total - wr_base), 334);
        checkOutput("armed_in_post", 32'(armed), 0);
        waitDone(500);
        checkOutput("total_writes", 32'(wr_total - wr_base), 434);
        checkOutput("start_addr_c1", 32'(start_addr), 50);
`ifdef CAP_TRIG_ADDR_EN
        exp_trig = 333;
`else
        exp_trig = 0;
`endif
        checkOutput("trig_addr_c1", 32'(trig_addr), 32'(exp_trig));
        checkOutput("done_we", 32'(we), 0);
        applyStimulus(1, 1, 1, 0);
        repeat (5) tick();
        checkOutput("done_pulse_count", 32'(pulse_total - pulse_base), 1);
        checkOutput("no_writes_in_done", 32'(wr_total - wr_base), 434);
        checkOutput("done_waddr_held", 32'(waddr), 50);

        // Capture 2: trig_pos 0 after host clear; arm needs a full buffer, trigger on wrap to 0
        trig_pos = 9'd0;
        applyStimulus(1, 1, 0, 0);
        wr_base = wr_total;
        waitArmed(1000);
        checkOutput("tp0_writes_at_arm", 32'(wr_total - wr_base), 384);
        checkOutput("tp0_waddr_wrap", 32'(waddr), 0);
        applyStimulus(1, 1, 0, 1);
        tick();
        applyStimulus(1, 1, 0, 0);
        checkOutput("tp0_pulse_next_cycle", 32'(set_capture_done), 1);
        checkOutput("tp0_start_addr", 32'(start_addr), 1);
        checkOutput("tp0_trig_addr", 32'(trig_addr), 0);
        checkOutput("tp0_total_writes", 32'(wr_total - wr_base), 385);
        checkOutput("tp0_we_done", 32'(we), 0);
        applyStimulus(1, 1, 1, 0);
        tick();

        // Capture 3: decim 2, trig_pos 511 clamps to 383, early trigger ignored
        decimator = 4'd2;
        trig_pos = 9'd511;
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        wr_base = wr_total;
        tick();
        applyStimulus(1, 1, 0, 1);
        checkOutput("dec_c1_we", 32'(we), 0);
        checkOutput("dec_c1_armed", 32'(armed), 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        checkOutput("dec_c2_we", 32'(we), 0);
        tick();
        checkOutput("dec_c3_we", 32'(we), 0);
        tick();
        checkOutput("dec_c4_we", 32'(we), 1);
        checkOutput("dec_c4_waddr", 32'(waddr), 0);
        checkOutput("dec_c4_armed", 32'(armed), 0);
        tick();
        checkOutput("dec_c5_armed", 32'(armed), 1);
        checkOutput("dec_c5_we", 32'(we), 0);
        tick();
        applyStimulus(1, 1, 0, 1);
        checkOutput("dec_c6_we", 32'(we), 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        checkOutput("dec_c7_we", 32'(we), 0);
        checkOutput("dec_c7_armed", 32'(armed), 0);
        tick();
        checkOutput("dec_c8_we", 32'(we), 1);
        checkOutput("dec_c8_waddr", 32'(waddr), 1);
        waitDone(2000);
        checkOutput("clamp_total_writes", 32'(wr_total - wr_base), 384);
        checkOutput("clamp_start_addr", 32'(start_addr), 0);
        checkOutput("clamp_trig_addr", 32'(trig_addr), 0);
        applyStimulus(1, 1, 1, 0);
        tick();

        // Abort mid-POST, then restart from address 0
        decimator = 4'd0;
        trig_pos = 9'd383;
        applyStimulus(1, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 0, 0);
        pulse_base = pulse_total;
        tick();
        tick();
        applyStimulus(1, 1, 0, 1);
        checkOutput("abort_armed", 32'(armed), 1);
        repeat (10) begin
            tick();
            applyStimulus(1, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("abort_waddr", 32'(waddr), 11);
        checkOutput("abort_last_we", 32'(we), 1);
        tick();
        checkOutput("abort_idle_we", 32'(we), 0);
        checkOutput("abort_idle_armed", 32'(armed), 0);
        repeat (3) tick();
        checkOutput("abort_no_pulse", 32'(pulse_total - pulse_base), 0);
        applyStimulus(1, 1, 0, 0);
        tick();
        checkOutput("restart_waddr", 32'(waddr), 0);
        checkOutput("restart_we", 32'(we), 1);

        // Asynchronous reset mid-capture
        repeat (5) tick();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("areset_waddr", 32'(waddr), 0);
        checkOutput("areset_we", 32'(we), 0);
        checkOutput("areset_armed", 32'(armed), 0);
        checkOutput("areset_done", 32'(set_capture_done), 0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
